// File: rtl/dnn_param_mem_fix12.sv
// ---------------------------------------------------------------------------
// dnn_param_mem_fix12
// Parameter/activation memory for the 12-bit fixed-point inference engine.
// The engine reads through a free-running 1-cycle-latency port while a
// host byte-stream loader fills the RAM (two bytes per word, low byte first).
//
// Ports
//   clk         system clock
//   rst         asynchronous active-low reset
//   mem_addr    engine read address
//   mem_data    signed read data, 1-cycle latency, 0 when out of range
//   load_start  pulse starting a load (sampled only when idle)
//   load_base   first word address of the load
//   load_count  number of words to load (0 allowed)
//   ld_valid    host byte valid
//   ld_byte     host byte
//   ld_ready    byte accepted this cycle when ld_valid is also high
//   busy        load in progress
//   load_done   one-cycle pulse at the end of a load
//   load_err    sticky overflow flag, cleared by the next accepted load_start
// ---------------------------------------------------------------------------
module dnn_param_mem_fix12 #(
   parameter int unsigned DATA_WIDTH = 12,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DEPTH      = 18878
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [ADDR_WIDTH-1:0]        mem_addr,
   output logic signed [DATA_WIDTH-1:0] mem_data,
   input  logic                         load_start,
   input  logic [ADDR_WIDTH-1:0]        load_base,
   input  logic [ADDR_WIDTH-1:0]        load_count,
   input  logic                         ld_valid,
   input  logic [7:0]                   ld_byte,
   output logic                         ld_ready,
   output logic                         busy,
   output logic                         load_done,
   output logic                         load_err
);

   localparam int unsigned           IDX_W   = $clog2(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LO   = 3'd1;
   localparam logic [2:0] S_HI   = 3'd2;
   localparam logic [2:0] S_WR   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [DATA_WIDTH-1:0] r_ram [DEPTH];

   logic [2:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH-1:0] r_remaining;
   logic [7:0]            r_b0;
   logic [DATA_WIDTH-1:0] r_word;
   logic                  r_load_err;
   logic                  r_ld_ready;
   logic                  r_busy;
   logic                  r_load_done;
   logic [DATA_WIDTH-1:0] r_mem_data;

   logic [2:0]            w_state_nxt;
   logic [ADDR_WIDTH-1:0] w_addr_nxt;
   logic [ADDR_WIDTH-1:0] w_remaining_nxt;
   logic [7:0]            w_b0_nxt;
   logic [DATA_WIDTH-1:0] w_word_nxt;
   logic                  w_load_err_nxt;
   logic                  w_we;
   logic                  w_accept;
   logic                  w_rd_in_range;
   logic [IDX_W-1:0]      w_rd_idx;

   assign w_accept      = ld_valid && r_ld_ready;
   assign w_rd_in_range = (mem_addr < DEPTH_A);
   assign w_rd_idx      = mem_addr[IDX_W-1:0];

   // Load sequencer: next state and datapath updates
   always_comb begin
      w_state_nxt     = r_state;
      w_addr_nxt      = r_addr;
      w_remaining_nxt = r_remaining;
      w_b0_nxt        = r_b0;
      w_word_nxt      = r_word;
      w_load_err_nxt  = r_load_err;
      w_we            = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (load_start) begin
               w_addr_nxt      = load_base;
               w_remaining_nxt = load_count;
               w_load_err_nxt  = 1'b0;
               w_state_nxt     = (load_count == '0) ? S_DONE : S_LO;
            end
         end
         S_LO: begin
            if (w_accept) begin
               w_b0_nxt    = ld_byte;
               w_state_nxt = S_HI;
            end
         end
         S_HI: begin
            if (w_accept) begin
               // Abort before the address could ever run past the RAM
               if (r_addr >= DEPTH_A) begin
                  w_load_err_nxt = 1'b1;
                  w_state_nxt    = S_DONE;
               end else begin
                  w_word_nxt  = DATA_WIDTH'({ld_byte[3:0], r_b0});
                  w_state_nxt = S_WR;
               end
            end
         end
         S_WR: begin
            w_we            = 1'b1;
            w_addr_nxt      = r_addr + ADDR_WIDTH'(1);
            w_remaining_nxt = r_remaining - ADDR_WIDTH'(1);
            w_state_nxt     = (r_remaining == ADDR_WIDTH'(1)) ? S_DONE : S_LO;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, datapath and registered status outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_remaining <= '0;
         r_b0        <= '0;
         r_word      <= '0;
         r_load_err  <= 1'b0;
         r_ld_ready  <= 1'b0;
         r_busy      <= 1'b0;
         r_load_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_addr      <= w_addr_nxt;
         r_remaining <= w_remaining_nxt;
         r_b0        <= w_b0_nxt;
         r_word      <= w_word_nxt;
         r_load_err  <= w_load_err_nxt;
         // Status flags track the state being entered so they line up with it
         r_ld_ready  <= (w_state_nxt == S_LO) || (w_state_nxt == S_HI);
         r_busy      <= (w_state_nxt == S_LO) || (w_state_nxt == S_HI) ||
                        (w_state_nxt == S_WR);
         r_load_done <= (w_state_nxt == S_DONE);
      end
   end

   // RAM write port; address is known in range once in WR
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_ram[r_addr[IDX_W-1:0]] <= r_word;
      end
   end

   // Free-running read port, read-before-write on address collision
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mem_data <= '0;
      end else if (w_rd_in_range) begin
         r_mem_data <= r_ram[w_rd_idx];
      end else begin
         r_mem_data <= '0;
      end
   end

   assign mem_data  = $signed(r_mem_data);
   assign ld_ready  = r_ld_ready;
   assign busy      = r_busy;
   assign load_done = r_load_done;
   assign load_err  = r_load_err;

endmodule
